zacore_imm_gen_pipe: RTL

Pipelined, XLEN-parametrised immediate generator for the decode stage.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake.
- Classifies the instruction format from its opcode.
- Produces the sign-extended immediate plus a format tag.
- Output goes through a 2-entry skid buffer so backpressure from the execute stage never creates a combinational ready path back to fetch.

---
 rtl/zacore_common.sv | 33 +++
 rtl/zacore_imm_extract.sv | 49 ++++
 rtl/zacore_imm_gen_pipe.sv | 73 +++++++
 3 files changed

// File: rtl/zacore_common.sv
// zacore_common: shared decode types, opcode constants and the immediate result record
package zacore_common;

    localparam int IMM_W = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        imm_fmt_e         fmt;
        logic             illegal;
    } imm_result_t;

endpackage

// File: rtl/zacore_imm_extract.sv
// zacore_imm_extract: opcode classification and immediate assembly; ZACORE_IMM_GEN_CSR_ZIMM_EN adds the CSR zimm format
module zacore_imm_extract
    import zacore_common::*;
#(
    parameter int XLEN    = 32,
    parameter bit RV64_EN = 1'b0
) (
    input  logic [31:0] inst,
    output imm_result_t res
);

    localparam logic [IMM_W-1:0] XMASK = {IMM_W{1'b1}} >> (IMM_W - XLEN);

    logic [6:0] opc;
    logic       s;
    logic       is_i;
    logic       is_sys;
    logic       is_z;

    assign opc    = inst[6:0];
    assign s      = inst[31];
    assign is_i   = opc == OPC_OP_IMM || opc == OPC_LOAD || opc == OPC_JALR || (RV64_EN && opc == OPC_OP_IMM_32);
    assign is_sys = opc == OPC_SYSTEM;
`ifdef ZACORE_IMM_GEN_CSR_ZIMM_EN
    assign is_z   = is_sys && inst[14];
`else
    assign is_z   = 1'b0;
`endif

    // classify by opcode, then select the format's bit shuffle, sign-extended and clipped to XLEN
    always_comb begin
        res.fmt     = is_i ? FMT_I
                    : opc == OPC_STORE ? FMT_S
                    : opc == OPC_BRANCH ? FMT_B
                    : (opc == OPC_LUI || opc == OPC_AUIPC) ? FMT_U
                    : opc == OPC_JAL ? FMT_J
                    : is_z ? FMT_Z
                    : FMT_NONE;
        res.illegal = res.fmt == FMT_NONE && !is_sys;
        res.imm     = XMASK & (res.fmt == FMT_I ? {{52{s}}, inst[31:20]}
                    : res.fmt == FMT_S ? {{52{s}}, inst[31:25], inst[11:7]}
                    : res.fmt == FMT_B ? {{51{s}}, s, inst[7], inst[30:25], inst[11:8], 1'b0}
                    : res.fmt == FMT_U ? {{32{s}}, inst[31:12], 12'b0}
                    : res.fmt == FMT_J ? {{43{s}}, s, inst[19:12], inst[20], inst[30:21], 1'b0}
                    : res.fmt == FMT_Z ? {59'b0, inst[19:15]}
                    : {IMM_W{1'b0}});
    end

endmodule

// File: rtl/zacore_imm_gen_pipe.sv
// zacore_imm_gen_pipe: decode-stage immediate generator behind a 2-entry skid buffer (CSR zimm via ZACORE_IMM_GEN_CSR_ZIMM_EN)
module zacore_imm_gen_pipe
    import zacore_common::*;
#(
    parameter int XLEN    = 32,
    parameter bit RV64_EN = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    imm_result_t res;
    imm_result_t main_q;
    imm_result_t skid_q;
    imm_result_t main_d;
    imm_result_t skid_d;
    logic        main_v;
    logic        skid_v;
    logic        main_v_d;
    logic        skid_v_d;
    logic        rdy_q;
    logic        load;
    logic        in_fire;
    logic        unused_imm;

    zacore_imm_extract #(.XLEN(XLEN), .RV64_EN(RV64_EN)) u_extract (
        .inst(in_inst),
        .res (res)
    );

    assign in_ready    = rdy_q && !rst;
    assign in_fire     = in_valid && in_ready;
    assign load        = !main_v || out_ready;
    assign out_valid   = main_v;
    assign out_imm     = main_q.imm[XLEN-1:0];
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign unused_imm  = ^main_q.imm;

    // main refills from skid first to keep FIFO order; a new result parks in skid only when main cannot take it
    always_comb begin
        main_v_d = load ? (skid_v || in_fire) : 1'b1;
        main_d   = !load ? main_q : skid_v ? skid_q : in_fire ? res : main_q;
        skid_v_d = load ? (skid_v && in_fire) : (skid_v || in_fire);
        skid_d   = (in_fire && (skid_v || !load)) ? res : skid_q;
    end

    // buffer state; ready is registered from next skid occupancy so out_ready never reaches in_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
            rdy_q  <= 1'b1;
        end else begin
            main_v <= main_v_d;
            skid_v <= skid_v_d;
            main_q <= main_d;
            skid_q <= skid_d;
            rdy_q  <= !skid_v_d;
        end
    end

endmodule
